// File: rtl/btn_pkg.sv
// Shared types and constant helpers for the button conditioner and its per-channel logic.
// Holds the repeat-state encoding and the counter-width function used to size the debounce and repeat counters.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Smallest width able to hold every value 0..max_val, same as $clog2(max_val+1).
    function automatic int cnt_width(input int max_val);
        int w;
        for (w = 1; (w < 31) && ((1 << w) <= max_val); w++) begin
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, counter debounce, registered press/release pulses and hold-to-repeat.
// Repeat logic is present only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined; otherwise action equals press.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit IDLE_LEVEL      = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic action,
    output logic press_next
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) ||
        (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
        $error("btn_channel: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   action_q, action_d;
    logic                   norm_s;
    logic                   repeat_pulse;

    assign sync_d[0] = btn_in;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    // Fold the idle polarity away so 1 always means "pressed" from here on.
    assign norm_s = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

    always_comb begin
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (norm_s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d   = norm_s;
            db_cnt_d  = '0;
            press_d   = norm_s;
            release_d = ~norm_s;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    rpt_state_e       rpt_state_q, rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_pulse_d;

    // Driven by the press/release events of this same edge, so the first repeat lands REPEAT_DELAY after press.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_pulse_d = 1'b0;
        case (rpt_state_q)
            IDLE: begin
                if (press_d) begin
                    rpt_state_d = DELAY;
                    rpt_cnt_d   = '0;
                end
            end
            DELAY: begin
                if (rpt_cnt_q == DELAY_LAST) begin
                    rpt_pulse_d = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_state_d = REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (rpt_cnt_q == PERIOD_LAST) begin
                    rpt_pulse_d = 1'b1;
                    rpt_cnt_d   = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            default: begin
                rpt_state_d = IDLE;
                rpt_cnt_d   = '0;
            end
        endcase
        // Release wins over a repeat falling due on the same edge.
        if (release_d) begin
            rpt_state_d = IDLE;
            rpt_cnt_d   = '0;
            rpt_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_state_q <= IDLE;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign repeat_pulse = rpt_pulse_d;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign action_d = press_d | repeat_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {SYNC_STAGES{IDLE_LEVEL}};
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            action_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            action_q  <= action_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign action        = action_q;
    assign press_next    = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: NUM_BTN independent btn_channel instances plus a registered any_press.
// Define BUTTON_CONDITIONER_AUTOREPEAT_EN for hold-to-repeat; the release output is release_pulse since release is reserved.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit IDLE_LEVEL      = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] action,
    output logic               any_press
);

    logic [NUM_BTN-1:0] press_next;
    logic               any_press_q, any_press_d;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_in       (btn_in[gi]),
            .level        (level[gi]),
            .press        (press[gi]),
            .release_pulse(release_pulse[gi]),
            .action       (action[gi]),
            .press_next   (press_next[gi])
        );
    end

    // Built from the channels' next-press terms so it rises on the same edge as press.
    assign any_press_d = |press_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one active-high-pin instance and one IDLE_LEVEL=1 instance.
// Repeat expectations apply when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined for the build.
module tb_button_conditioner;

    localparam int NB = 4;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_in, level, press, release_pulse, action;
    logic          any_press;
    logic [NB-1:0] btn_inv, level_i, press_i, release_i, action_i;
    logic          any_press_i;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN(NB), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IDLE_LEVEL(1'b0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level), .press(press),
        .release_pulse(release_pulse), .action(action), .any_press(any_press)
    );

    button_conditioner #(
        .NUM_BTN(NB), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IDLE_LEVEL(1'b1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_inv), .level(level_i), .press(press_i),
        .release_pulse(release_i), .action(action_i), .any_press(any_press_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ch(input string tag, input int k, input int ch,
                          input bit e_press, input bit e_rel, input bit e_lvl, input bit e_act);
        chk($sformatf("%s k=%0d press[%0d]", tag, k, ch), press[ch], e_press);
        chk($sformatf("%s k=%0d release[%0d]", tag, k, ch), release_pulse[ch], e_rel);
        chk($sformatf("%s k=%0d level[%0d]", tag, k, ch), level[ch], e_lvl);
        chk($sformatf("%s k=%0d action[%0d]", tag, k, ch), action[ch], e_act);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " level"}, level, 0);
        chk({tag, " press"}, press, 0);
        chk({tag, " release"}, release_pulse, 0);
        chk({tag, " action"}, action, 0);
        chk({tag, " any_press"}, any_press, 0);
        chk({tag, " level_i"}, level_i, 0);
        chk({tag, " press_i"}, press_i, 0);
        chk({tag, " action_i"}, action_i, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        btn_in  = '0;
        btn_inv = '1;
        #2;
        chk_all_zero("reset_state");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_all_zero($sformatf("post_reset k=%0d", k));
        end
        $display("scenario reset_state: %0d compared so far", n_cmp);

        // Clean press then release on channel 0; released before its first repeat.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk_ch("clean", k, 0, k == 6, k == 14, (k >= 6) && (k < 14), k == 6);
            chk($sformatf("clean k=%0d any_press", k), any_press, k == 6);
            if (k == 8) btn_in[0] = 1'b0;
        end
        $display("scenario clean_press: %0d compared so far", n_cmp);

        // Three-cycle glitch is rejected, four-cycle pulse is accepted.
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_ch("glitch3", k, 1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 3) btn_in[1] = 1'b0;
        end
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_ch("pulse4", k, 1, k == 6, k == 10, (k >= 6) && (k < 10), k == 6);
            if (k == 4) btn_in[1] = 1'b0;
        end
        $display("scenario glitch: %0d compared so far", n_cmp);

        // Channel 2: press, bounce, then release that collides with a due repeat.
        btn_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_ch("bounce_press", k, 2, k == 6, 1'b0, k >= 6, k == 6);
        end
        btn_in[2] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            chk_ch("bounce_rel", k, 2, 1'b0, k == 14, k < 14, AR && ((k == 8) || (k == 11)));
            if (k == 2) btn_in[2] = 1'b1;
            if (k == 4) btn_in[2] = 1'b0;
            if (k == 6) btn_in[2] = 1'b1;
            if (k == 8) btn_in[2] = 1'b0;
        end
        $display("scenario bounce_collision: %0d compared so far", n_cmp);

        // Channel 3 auto-repeat: t0=6, repeats at 16,19,22,...; release at 30 stops them.
        btn_in[3] = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            step();
            chk_ch("repeat", k, 3, k == 6, k == 30, (k >= 6) && (k < 30),
                   (k == 6) || (AR && ((k == 16) || (k == 19) || (k == 22) || (k == 25) || (k == 28))));
            if (k == 24) btn_in[3] = 1'b0;
        end
        $display("scenario auto_repeat: %0d compared so far", n_cmp);

        // Inverted pins: pressing means driving 0.
        btn_inv[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("inv k=%0d press_i", k), press_i, (k == 6) ? 4'h1 : 4'h0);
            chk($sformatf("inv k=%0d release_i", k), release_i, (k == 14) ? 4'h1 : 4'h0);
            chk($sformatf("inv k=%0d level_i", k), level_i, ((k >= 6) && (k < 14)) ? 4'h1 : 4'h0);
            chk($sformatf("inv k=%0d action_i", k), action_i, (k == 6) ? 4'h1 : 4'h0);
            chk($sformatf("inv k=%0d any_press_i", k), any_press_i, k == 6);
            if (k == 8) btn_inv[0] = 1'b1;
        end
        $display("scenario inverted: %0d compared so far", n_cmp);

        // Reset mid-debounce with all pins held, then again mid-repeat.
        btn_in  = '1;
        btn_inv = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("mid_db k=%0d press", k), press, 0);
        end
        rst_n = 1'b0;
        #2;
        chk_all_zero("rst_mid_db");
        for (int k = 1; k <= 2; k++) begin
            step();
            chk_all_zero($sformatf("rst_hold k=%0d", k));
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("rst_rel k=%0d press", k), press, (k == 6) ? 4'hF : 4'h0);
            chk($sformatf("rst_rel k=%0d level", k), level, (k >= 6) ? 4'hF : 4'h0);
            chk($sformatf("rst_rel k=%0d action", k), action,
                ((k == 6) || (AR && (k == 16))) ? 4'hF : 4'h0);
            chk($sformatf("rst_rel k=%0d any_press", k), any_press, k == 6);
            chk($sformatf("rst_rel k=%0d press_i", k), press_i, (k == 6) ? 4'hF : 4'h0);
            chk($sformatf("rst_rel k=%0d level_i", k), level_i, (k >= 6) ? 4'hF : 4'h0);
        end
        rst_n = 1'b0;
        #2;
        chk_all_zero("rst_mid_rpt");
        $display("scenario reset_mid_op: %0d compared so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
